// File: rtl/fifo_wptr_wfull_if.sv
// Write-side signal bundle between the producer and the write-pointer/full controller
// of the asynchronous FIFO.
interface fifo_wptr_wfull_if #(
    parameter int Address_width = 3
);
    logic                     Winc;
    logic [Address_width:0]   W2q_rptr;
    logic                     Woverflow_clr;
    logic                     Wclken;
    logic [Address_width-1:0] Waddr;
    logic [Address_width:0]   Wptr;
    logic                     Wfull;
    logic                     Walmost_full;
    logic [Address_width:0]   Wlevel;
    logic                     Woverflow;

    modport master (
        output Winc, W2q_rptr, Woverflow_clr,
        input  Wclken, Waddr, Wptr, Wfull, Walmost_full, Wlevel, Woverflow
    );

    modport slave (
        input  Winc, W2q_rptr, Woverflow_clr,
        output Wclken, Waddr, Wptr, Wfull, Walmost_full, Wlevel, Woverflow
    );
endinterface

// File: rtl/fifo_wptr_wfull.sv
// Write-clock-domain pointer and full/level controller of the asynchronous FIFO:
// Gray write pointer, memory write port, conservative level, almost-full and sticky overflow.
module fifo_wptr_wfull #(
    parameter int Address_width         = 3,
    parameter int Almost_full_threshold = 6
) (
    input  logic             Wclk,
    input  logic             Wrst,
    fifo_wptr_wfull_if.slave bus
);
    localparam int          AW     = Address_width;
    localparam logic [AW:0] AF_THR = Almost_full_threshold[AW:0];

    function automatic logic [AW:0] bin2gray(input logic [AW:0] b);
        return (b >> 1) ^ b;
    endfunction

    // Prefix XOR from the MSB down.
    function automatic logic [AW:0] gray2bin(input logic [AW:0] g);
        logic [AW:0] b;
        b[AW] = g[AW];
        for (int i = AW - 1; i >= 0; i--) begin
            b[i] = b[i + 1] ^ g[i];
        end
        return b;
    endfunction

    logic [AW:0] wbin_r;
    logic [AW:0] wptr_r;
    logic        wfull_r;
    logic        walmost_full_r;
    logic [AW:0] wlevel_r;
    logic        woverflow_r;

    logic        accept_s;
    logic [AW:0] wbin_next_s;
    logic [AW:0] wgray_next_s;
    logic [AW:0] rbin_s;
    logic [AW:0] level_next_s;
    logic [AW:0] rptr_full_s;
    logic        full_next_s;
    logic        overflow_next_s;

    // Next-state pointer, level and flag computation from registered state and synced read pointer.
    always_comb begin
        accept_s        = bus.Winc & ~wfull_r;
        wbin_next_s     = wbin_r + {{AW{1'b0}}, accept_s};
        wgray_next_s    = bin2gray(wbin_next_s);
        rbin_s          = gray2bin(bus.W2q_rptr);
        level_next_s    = wbin_next_s - rbin_s;
        // Full when the write pointer is exactly one lap ahead: top two Gray bits inverted.
        rptr_full_s     = {~bus.W2q_rptr[AW:AW-1], bus.W2q_rptr[AW-2:0]};
        full_next_s     = (wgray_next_s == rptr_full_s);
        overflow_next_s = (bus.Winc & wfull_r) | (woverflow_r & ~bus.Woverflow_clr);
    end

    // Write-domain state registers with synchronous reset.
    always_ff @(posedge Wclk) begin
        if (Wrst) begin
            wbin_r         <= {(AW + 1){1'b0}};
            wptr_r         <= {(AW + 1){1'b0}};
            wfull_r        <= 1'b0;
            walmost_full_r <= 1'b0;
            wlevel_r       <= {(AW + 1){1'b0}};
            woverflow_r    <= 1'b0;
        end else begin
            wbin_r         <= wbin_next_s;
            wptr_r         <= wgray_next_s;
            wfull_r        <= full_next_s;
            walmost_full_r <= (level_next_s >= AF_THR);
            wlevel_r       <= level_next_s;
            woverflow_r    <= overflow_next_s;
        end
    end

    // The memory write enable is combinational so data lands on the edge the pointer advances.
    assign bus.Wclken       = bus.Winc & ~wfull_r & ~Wrst;
    assign bus.Waddr        = wbin_r[AW-1:0];
    assign bus.Wptr         = wptr_r;
    assign bus.Wfull        = wfull_r;
    assign bus.Walmost_full = walmost_full_r;
    assign bus.Wlevel       = wlevel_r;
    assign bus.Woverflow    = woverflow_r;

endmodule

// File: tb/tb_fifo_wptr_wfull.sv
// Self-checking bench for fifo_wptr_wfull (Address_width=3, Almost_full_threshold=6).
module tb_fifo_wptr_wfull;
    logic Wclk;
    logic Wrst;

    fifo_wptr_wfull_if #(.Address_width(3)) bus ();

    fifo_wptr_wfull #(
        .Address_width        (3),
        .Almost_full_threshold(6)
    ) dut (
        .Wclk(Wclk),
        .Wrst(Wrst),
        .bus (bus)
    );

    initial Wclk = 1'b0;
    always #5 Wclk = ~Wclk;

    typedef struct {
        logic       rst;
        logic       inc;
        logic [3:0] rptr;
        logic       clr;
        logic       ck;     // expected Wclken before the edge
        logic [2:0] paddr;  // expected Waddr before the edge (checked when a write is expected)
        logic [3:0] ptr;
        logic [2:0] addr;
        logic       full;
        logic       af;
        logic [3:0] lvl;
        logic       ovf;
    } vec_t;

    vec_t sb[$];
    vec_t tbl[16];
    int   passed = 0;
    int   total  = 0;

    function automatic vec_t mk(input logic rst, input logic inc, input logic [3:0] rptr,
                                input logic clr, input logic ck, input logic [2:0] paddr,
                                input logic [3:0] ptr, input logic [2:0] addr, input logic full,
                                input logic af, input logic [3:0] lvl, input logic ovf);
        vec_t v;
        v.rst = rst; v.inc = inc; v.rptr = rptr; v.clr = clr; v.ck = ck; v.paddr = paddr;
        v.ptr = ptr; v.addr = addr; v.full = full; v.af = af; v.lvl = lvl; v.ovf = ovf;
        return v;
    endfunction

    function automatic logic [3:0] gray4(input int n);
        logic [3:0] b;
        b = n[3:0];
        return b ^ (b >> 1);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    endtask

    task automatic apply(input vec_t v);
        vec_t e;
        @(negedge Wclk);
        Wrst              = v.rst;
        bus.Winc          = v.inc;
        bus.W2q_rptr      = v.rptr;
        bus.Woverflow_clr = v.clr;
        #1;
        chk("wclken", {31'd0, bus.Wclken}, {31'd0, v.ck});
        if (v.ck) chk("waddr_pre", {29'd0, bus.Waddr}, {29'd0, v.paddr});
        sb.push_back(v);
        @(posedge Wclk);
        #1;
        e = sb.pop_front();
        chk("wptr",         {28'd0, bus.Wptr},         {28'd0, e.ptr});
        chk("waddr",        {29'd0, bus.Waddr},        {29'd0, e.addr});
        chk("wfull",        {31'd0, bus.Wfull},        {31'd0, e.full});
        chk("walmost_full", {31'd0, bus.Walmost_full}, {31'd0, e.af});
        chk("wlevel",       {28'd0, bus.Wlevel},       {28'd0, e.lvl});
        chk("woverflow",    {31'd0, bus.Woverflow},    {31'd0, e.ovf});
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish (got running, expected finished)");
        $fatal(1);
    end

    initial begin
        Wrst = 1'b1; bus.Winc = 1'b0; bus.W2q_rptr = 4'b0000; bus.Woverflow_clr = 1'b0;

        // Reset with Winc held high, fill to full, overflow handling, release and drain.
        tbl[0]  = mk(1'b1, 1'b1, 4'b0000, 1'b0, 1'b0, 3'd0, 4'b0000, 3'd0, 1'b0, 1'b0, 4'd0, 1'b0);
        tbl[1]  = mk(1'b1, 1'b1, 4'b0000, 1'b0, 1'b0, 3'd0, 4'b0000, 3'd0, 1'b0, 1'b0, 4'd0, 1'b0);
        tbl[2]  = mk(1'b0, 1'b1, 4'b0000, 1'b0, 1'b1, 3'd0, 4'b0001, 3'd1, 1'b0, 1'b0, 4'd1, 1'b0);
        tbl[3]  = mk(1'b0, 1'b1, 4'b0000, 1'b0, 1'b1, 3'd1, 4'b0011, 3'd2, 1'b0, 1'b0, 4'd2, 1'b0);
        tbl[4]  = mk(1'b0, 1'b1, 4'b0000, 1'b0, 1'b1, 3'd2, 4'b0010, 3'd3, 1'b0, 1'b0, 4'd3, 1'b0);
        tbl[5]  = mk(1'b0, 1'b1, 4'b0000, 1'b0, 1'b1, 3'd3, 4'b0110, 3'd4, 1'b0, 1'b0, 4'd4, 1'b0);
        tbl[6]  = mk(1'b0, 1'b1, 4'b0000, 1'b0, 1'b1, 3'd4, 4'b0111, 3'd5, 1'b0, 1'b0, 4'd5, 1'b0);
        tbl[7]  = mk(1'b0, 1'b1, 4'b0000, 1'b0, 1'b1, 3'd5, 4'b0101, 3'd6, 1'b0, 1'b1, 4'd6, 1'b0);
        tbl[8]  = mk(1'b0, 1'b1, 4'b0000, 1'b0, 1'b1, 3'd6, 4'b0100, 3'd7, 1'b0, 1'b1, 4'd7, 1'b0);
        tbl[9]  = mk(1'b0, 1'b1, 4'b0000, 1'b0, 1'b1, 3'd7, 4'b1100, 3'd0, 1'b1, 1'b1, 4'd8, 1'b0);
        tbl[10] = mk(1'b0, 1'b1, 4'b0000, 1'b0, 1'b0, 3'd0, 4'b1100, 3'd0, 1'b1, 1'b1, 4'd8, 1'b1);
        tbl[11] = mk(1'b0, 1'b0, 4'b0000, 1'b1, 1'b0, 3'd0, 4'b1100, 3'd0, 1'b1, 1'b1, 4'd8, 1'b0);
        tbl[12] = mk(1'b0, 1'b1, 4'b0000, 1'b1, 1'b0, 3'd0, 4'b1100, 3'd0, 1'b1, 1'b1, 4'd8, 1'b1);
        // Read pointer advances while full and Winc=1: write still rejected, full releases.
        tbl[13] = mk(1'b0, 1'b1, 4'b0001, 1'b0, 1'b0, 3'd0, 4'b1100, 3'd0, 1'b0, 1'b1, 4'd7, 1'b1);
        tbl[14] = mk(1'b0, 1'b0, 4'b0010, 1'b1, 1'b0, 3'd0, 4'b1100, 3'd0, 1'b0, 1'b0, 4'd5, 1'b0);
        tbl[15] = mk(1'b0, 1'b1, 4'b0010, 1'b0, 1'b1, 3'd0, 4'b1101, 3'd1, 1'b0, 1'b1, 4'd6, 1'b0);

        for (int i = 0; i < 16; i++) apply(tbl[i]);

        // Wrap-around: 16 writes with the read pointer trailing by two entries.
        apply(mk(1'b1, 1'b0, 4'b0000, 1'b0, 1'b0, 3'd0, 4'b0000, 3'd0, 1'b0, 1'b0, 4'd0, 1'b0));
        for (int i = 1; i <= 16; i++) begin
            logic [3:0] rp;
            logic [3:0] lv;
            logic [2:0] pa;
            logic [2:0] na;
            rp = (i <= 2) ? 4'b0000 : gray4(i - 2);
            lv = (i < 2) ? 4'd1 : 4'd2;
            pa = 3'((i - 1) % 8);
            na = 3'(i % 8);
            apply(mk(1'b0, 1'b1, rp, 1'b0, 1'b1, pa, gray4(i % 16), na, 1'b0, 1'b0, lv, 1'b0));
        end

        // Reset mid-stream at level 5 with Winc high, then the next write starts at address 0.
        apply(mk(1'b1, 1'b0, 4'b0000, 1'b0, 1'b0, 3'd0, 4'b0000, 3'd0, 1'b0, 1'b0, 4'd0, 1'b0));
        for (int k = 1; k <= 5; k++) begin
            apply(mk(1'b0, 1'b1, 4'b0000, 1'b0, 1'b1, 3'(k - 1), gray4(k), 3'(k), 1'b0, 1'b0,
                     4'(k), 1'b0));
        end
        apply(mk(1'b1, 1'b1, 4'b0000, 1'b0, 1'b0, 3'd0, 4'b0000, 3'd0, 1'b0, 1'b0, 4'd0, 1'b0));
        apply(mk(1'b0, 1'b1, 4'b0000, 1'b0, 1'b1, 3'd0, 4'b0001, 3'd1, 1'b0, 1'b0, 4'd1, 1'b0));

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/fifo_wptr_wfull.md
Name: fifo_wptr_wfull

Overview:
Write-side pointer and full-flag controller for the team's asynchronous FIFO; the counterpart of the read-pointer/empty block. It lives entirely in the write clock domain. It consumes the read pointer after it has been synchronised into the write domain, produces the Gray write pointer that is sent to the read domain, and produces the memory write address and enable. It also reports a conservative fill level, an almost-full flag and a sticky overflow flag.

Parameters:
Address_width, 3, log2 of FIFO depth (depth = 2^Address_width); must be >= 2
Almost_full_threshold, 6, Wlevel value at or above which Walmost_full asserts; range 1..2^Address_width

Ports:
Wclk  input  1  write-domain clock; all state updates on rising edge
Wrst  input  1  synchronous, active-high reset
Winc  input  1  write request from producer
W2q_rptr  input  Address_width+1  Gray read pointer, already synchronised into Wclk domain
Woverflow_clr  input  1  clears sticky overflow flag
Wclken  output  1  memory write enable (combinational)
Waddr  output  Address_width  memory write address (binary)
Wptr  output  Address_width+1  registered Gray write pointer, to read-domain synchroniser
Wfull  output  1  FIFO full (registered)
Walmost_full  output  1  Wlevel >= Almost_full_threshold (registered)
Wlevel  output  Address_width+1  conservative occupancy, 0..2^Address_width (registered)
Woverflow  output  1  sticky: a write was attempted while full

Behaviour:
- Internal binary counter Wbin, width Address_width+1.
- Wbin_next = Wbin + (Winc & ~Wfull), modulo 2^(Address_width+1).
- Wgray_next = (Wbin_next >> 1) ^ Wbin_next.
- Each edge: Wbin <= Wbin_next; Wptr <= Wgray_next. Wptr has one cycle of latency from the accepted write; only one bit changes per increment.
- Waddr = Wbin[Address_width-1:0], taken from the registered counter.
- Wclken = Winc & ~Wfull & ~Wrst. Data is written at Waddr on the same edge on which the pointer advances.
- Full: Wfull <= (Wgray_next == {~W2q_rptr[Address_width:Address_width-1], W2q_rptr[Address_width-2:0]}). This means full asserts on the same edge as the write that fills the FIFO, with no extra cycle.
- Level:
  - rbin = Gray-to-binary of W2q_rptr (XOR prefix from the MSB down).
  - Wlevel <= Wbin_next - rbin, modulo 2^(Address_width+1).
  - Because the read pointer lags the true read position, Wlevel is always >= true occupancy and never exceeds 2^Address_width.
- Walmost_full <= ((Wbin_next - rbin) >= Almost_full_threshold), using the same edge and the same source as Wlevel.
- Overflow: Woverflow <= (Winc & Wfull) | (Woverflow & ~Woverflow_clr).
  - Set has priority over a simultaneous clear.
  - A rejected write changes no pointer, address or level.
- Reset (Wrst=1 at an edge):
  - Wbin=0, Wptr=0, Wfull=0, Walmost_full=0, Wlevel=0, Woverflow=0.
  - Wclken is forced to 0 while Wrst is high.
  - Reset overrides Winc; reset mid-operation discards all state on that edge.
- Wrap-around: the extra MSB distinguishes full from empty. After 2^(Address_width+1) accepted writes Wptr returns to 0. Equal pointers mean empty (level 0), never full.
- Full release: when W2q_rptr advances while full with Winc=0, Wfull deasserts on the next edge. If Winc=1 on that edge, the write is accepted only if Wfull is already low, since the registered Wfull gates Wbin_next.
- W2q_rptr is trusted as a valid Gray value. No checking of pointer ordering is performed.

Test Plan:
1. Reset with Winc held at 1: assert Wrst for 2 edges -> Wclken=0, Wptr=0000, Waddr=0, Wfull=0, Wlevel=0, Woverflow=0.
2. Fill with W2q_rptr=0000 and 8 consecutive Winc pulses -> Wptr sequence 0001,0011,0010,0110,0111,0101,0100,1100. Walmost_full rises after the 6th write, Wlevel=8 and Wfull=1 after the 8th write.
3. Hold Winc=1 while full -> Wclken=0, Wptr stays 1100, Waddr stays 0, Woverflow=1. Then pulse Woverflow_clr -> Woverflow=0. Assert Winc and Woverflow_clr on the same edge while full -> Woverflow stays 1.
4. Drain: from full, set W2q_rptr=0010 (binary 3) with Winc=0 -> next edge Wfull=0, Wlevel=5, Walmost_full=0. Then one write -> Waddr=0 written, Wlevel=6, Walmost_full=1.
5. Wrap: 16 writes, with W2q_rptr trailing by 2 entries -> Wptr returns to 0000 after the 16th write. Wfull never asserts and Wlevel stays 2 in steady state.
6. Reset mid-stream: Wrst=1 for one edge at Wlevel=5 with Winc=1 -> all outputs return to reset values, and the next write uses Waddr=0.
